// File: rtl/alu_control_mc_if.sv
// alu_control_mc_if
//   Groups the request handshake, result and sequencing signals of the
//   LEGv8 multi-cycle ALU control unit.
//   master : the requester (main control / testbench) that drives the request
//   slave  : the ALU control unit itself
//   Request : In_Valid, ALU_Op, Op_Code, Flush    (master -> slave)
//   Result  : In_Ready, ALU_In, Out_Valid, Illegal, Busy, Mul_Start,
//             Div_Start                           (slave -> master)
interface alu_control_mc_if #(
  parameter int OPCODE_W = 11,
  parameter int CTRL_W   = 4
);
  logic                In_Valid;
  logic                In_Ready;
  logic [1:0]          ALU_Op;
  logic [OPCODE_W-1:0] Op_Code;
  logic                Flush;
  logic [CTRL_W-1:0]   ALU_In;
  logic                Out_Valid;
  logic                Illegal;
  logic                Busy;
  logic                Mul_Start;
  logic                Div_Start;

  modport master (
    output In_Valid, ALU_Op, Op_Code, Flush,
    input  In_Ready, ALU_In, Out_Valid, Illegal, Busy, Mul_Start, Div_Start
  );

  modport slave (
    input  In_Valid, ALU_Op, Op_Code, Flush,
    output In_Ready, ALU_In, Out_Valid, Illegal, Busy, Mul_Start, Div_Start
  );
endinterface

// File: rtl/alu_control_mc.sv
// alu_control_mc
//   Registered ALU control unit for the multi-cycle LEGv8 datapath. Decodes
//   ALU_Op plus the R-format opcode into the ALU control word and sequences
//   the iterative MUL / UDIV units with a countdown timer.
//   Clk      : rising-edge clock
//   Reset_n  : asynchronous active-low reset
//   bus      : request/result bundle (slave side), see alu_control_mc_if
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | ready for a request; single-cycle results return on next edge
//   MULTI | MUL/UDIV in flight; counter runs down to the result edge
module alu_control_mc #(
  parameter int OPCODE_W = 11,
  parameter int CTRL_W   = 4,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 16,
  parameter int CNT_W    = 5
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  alu_control_mc_if.slave      bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MULTI = 1'b1
  } state_t;

  localparam logic [CTRL_W-1:0] CODE_AND  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] CODE_ORR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] CODE_ADD  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] CODE_SUB  = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] CODE_PASS = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] CODE_MUL  = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] CODE_DIV  = CTRL_W'(4'b1001);
  localparam logic [CTRL_W-1:0] CODE_ILL  = CTRL_W'(4'b1111);

  localparam logic [10:0] OPC_MUL  = 11'b10011011000;
  localparam logic [10:0] OPC_UDIV = 11'b10011010110;

  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 2);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CTRL_W-1:0]   alu_in_q, alu_in_d;
  logic                out_valid_q, out_valid_d;
  logic                illegal_q, illegal_d;
  logic                mul_start_q, mul_start_d;
  logic                div_start_q, div_start_d;

  logic [CTRL_W-1:0]   dec_code;
  logic                dec_ill;
  logic                dec_mul;
  logic                dec_div;
  logic                in_ready;
  logic                accept;
  logic [10:0]         opc;

  assign opc = bus.Op_Code[10:0];

  // Decode. The X-safe structure matters: an unknown ALU_Op lands in the
  // default arm and an unknown opcode fails every equality test, so both
  // fall through to the illegal code instead of keeping a stale value.
  always_comb begin
    dec_code = CODE_ILL;
    dec_ill  = 1'b1;
    dec_mul  = 1'b0;
    dec_div  = 1'b0;
    case (bus.ALU_Op)
      2'b00: begin
        dec_code = CODE_ADD;
        dec_ill  = 1'b0;
      end
      2'b01: begin
        dec_code = CODE_PASS;
        dec_ill  = 1'b0;
      end
      2'b10: begin
        if (opc == OPC_MUL) begin
          dec_code = CODE_MUL;
          dec_ill  = 1'b0;
          dec_mul  = 1'b1;
        end else if (opc == OPC_UDIV) begin
          dec_code = CODE_DIV;
          dec_ill  = 1'b0;
          dec_div  = 1'b1;
        end else if (opc[10:9] == 2'b11) begin
          dec_code = CODE_SUB;
          dec_ill  = 1'b0;
        end else if (opc[10:8] == 3'b101) begin
          dec_code = CODE_ORR;
          dec_ill  = 1'b0;
        end else if (opc[10:3] == 8'b10001010) begin
          dec_code = CODE_AND;
          dec_ill  = 1'b0;
        end else if (opc[10:3] == 8'b10001011) begin
          dec_code = CODE_ADD;
          dec_ill  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign accept   = bus.In_Valid & in_ready & ~bus.Flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_in_d    = alu_in_q;
    illegal_d   = illegal_q;
    out_valid_d = 1'b0;
    mul_start_d = 1'b0;
    div_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_in_d  = dec_code;
          illegal_d = dec_ill;
          if (dec_mul) begin
            state_d     = MULTI;
            cnt_d       = MUL_CNT_INIT;
            mul_start_d = 1'b1;
          end else if (dec_div) begin
            state_d     = MULTI;
            cnt_d       = DIV_CNT_INIT;
            div_start_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
          end
        end
      end
      MULTI: begin
        // Flush is checked first so an abort on the terminal-count cycle
        // still suppresses the result.
        if (bus.Flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_in_q    <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_in_q    <= alu_in_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
    end
  end

  assign bus.In_Ready  = in_ready;
  assign bus.Busy      = (state_q == MULTI);
  assign bus.ALU_In    = alu_in_q;
  assign bus.Out_Valid = out_valid_q;
  assign bus.Illegal   = illegal_q;
  assign bus.Mul_Start = mul_start_q;
  assign bus.Div_Start = div_start_q;

endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc
//   Directed bench for alu_control_mc: reset values, single-cycle decode
//   table, MUL timing with back-to-back accept, UDIV flush, flush rules and
//   asynchronous reset mid-operation.
module tb_alu_control_mc;
  logic Clk;
  logic Reset_n;
  int   n_cmp;
  int   n_err;
  int   ov_seen;

  alu_control_mc_if #(.OPCODE_W(11), .CTRL_W(4)) bus ();

  alu_control_mc #(
    .OPCODE_W(11), .CTRL_W(4), .MUL_LAT(4), .DIV_LAT(16), .CNT_W(5)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [10:0] opc, input logic fl);
    bus.In_Valid = v;
    bus.ALU_Op   = op;
    bus.Op_Code  = opc;
    bus.Flush    = fl;
  endtask

  logic [1:0]  t_op  [8];
  logic [10:0] t_opc [8];
  logic [3:0]  t_code[8];
  logic        t_ill [8];

  initial begin
    n_cmp = 0;
    n_err = 0;
    t_op[0] = 2'b00; t_opc[0] = 11'b00000000000; t_code[0] = 4'b0010; t_ill[0] = 1'b0;
    t_op[1] = 2'b01; t_opc[1] = 11'b00000000000; t_code[1] = 4'b0111; t_ill[1] = 1'b0;
    t_op[2] = 2'b10; t_opc[2] = 11'b11001011000; t_code[2] = 4'b0110; t_ill[2] = 1'b0;
    t_op[3] = 2'b10; t_opc[3] = 11'b10101010000; t_code[3] = 4'b0001; t_ill[3] = 1'b0;
    t_op[4] = 2'b10; t_opc[4] = 11'b10001010101; t_code[4] = 4'b0000; t_ill[4] = 1'b0;
    t_op[5] = 2'b11; t_opc[5] = 11'b10001011000; t_code[5] = 4'b1111; t_ill[5] = 1'b1;
    t_op[6] = 2'b10; t_opc[6] = 11'b00000000000; t_code[6] = 4'b1111; t_ill[6] = 1'b1;
    t_op[7] = 2'b10; t_opc[7] = 11'b10011011001; t_code[7] = 4'b1111; t_ill[7] = 1'b1;

    Reset_n = 1'b0;
    drive(1'b0, 2'b00, 11'd0, 1'b0);
    step();
    step();
    chk("rst_in_ready", bus.In_Ready, 1);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_out_valid", bus.Out_Valid, 0);
    chk("rst_alu_in", bus.ALU_In, 0);
    chk("rst_illegal", bus.Illegal, 0);
    chk("rst_mul_start", bus.Mul_Start, 0);
    chk("rst_div_start", bus.Div_Start, 0);
    Reset_n = 1'b1;
    step();

    // single ADD
    drive(1'b1, 2'b10, 11'b10001011000, 1'b0);
    step();
    drive(1'b0, 2'b00, 11'd0, 1'b0);
    chk("add_ov", bus.Out_Valid, 1);
    chk("add_code", bus.ALU_In, 4'b0010);
    chk("add_ill", bus.Illegal, 0);
    chk("add_rdy", bus.In_Ready, 1);
    step();
    chk("add_ov_drop", bus.Out_Valid, 0);
    chk("add_hold", bus.ALU_In, 4'b0010);

    // back-to-back decode table, one accept per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, t_op[i], t_opc[i], 1'b0);
      step();
      chk($sformatf("tbl%0d_ov", i), bus.Out_Valid, 1);
      chk($sformatf("tbl%0d_code", i), bus.ALU_In, t_code[i]);
      chk($sformatf("tbl%0d_ill", i), bus.Illegal, t_ill[i]);
      chk($sformatf("tbl%0d_busy", i), bus.Busy, 0);
    end
    drive(1'b0, 2'b00, 11'd0, 1'b0);
    step();
    chk("tbl_ov_drop", bus.Out_Valid, 0);
    chk("tbl_ill_hold", bus.Illegal, 1);

    // MUL, accept in cycle 0
    drive(1'b1, 2'b10, 11'b10011011000, 1'b0);
    step();
    drive(1'b0, 2'b00, 11'd0, 1'b0);
    chk("mul_c1_start", bus.Mul_Start, 1);
    chk("mul_c1_dstart", bus.Div_Start, 0);
    chk("mul_c1_busy", bus.Busy, 1);
    chk("mul_c1_rdy", bus.In_Ready, 0);
    chk("mul_c1_ov", bus.Out_Valid, 0);
    chk("mul_c1_code", bus.ALU_In, 4'b1000);
    chk("mul_c1_ill", bus.Illegal, 0);
    step();
    chk("mul_c2_start", bus.Mul_Start, 0);
    chk("mul_c2_busy", bus.Busy, 1);
    chk("mul_c2_ov", bus.Out_Valid, 0);
    step();
    chk("mul_c3_busy", bus.Busy, 1);
    chk("mul_c3_rdy", bus.In_Ready, 0);
    chk("mul_c3_ov", bus.Out_Valid, 0);
    step();
    chk("mul_c4_ov", bus.Out_Valid, 1);
    chk("mul_c4_code", bus.ALU_In, 4'b1000);
    chk("mul_c4_rdy", bus.In_Ready, 1);
    chk("mul_c4_busy", bus.Busy, 0);
    drive(1'b1, 2'b10, 11'b10001011000, 1'b0);
    step();
    drive(1'b0, 2'b00, 11'd0, 1'b0);
    chk("mul_c5_ov", bus.Out_Valid, 1);
    chk("mul_c5_code", bus.ALU_In, 4'b0010);

    // UDIV, In_Valid held through cycles 1-6, Flush in cycle 7
    step();
    drive(1'b1, 2'b10, 11'b10011010110, 1'b0);
    step();
    drive(1'b1, 2'b00, 11'd0, 1'b0);
    chk("div_c1_start", bus.Div_Start, 1);
    chk("div_c1_mstart", bus.Mul_Start, 0);
    chk("div_c1_code", bus.ALU_In, 4'b1001);
    chk("div_c1_busy", bus.Busy, 1);
    for (int c = 2; c <= 7; c++) begin
      step();
      chk($sformatf("div_c%0d_ov", c), bus.Out_Valid, 0);
      chk($sformatf("div_c%0d_code", c), bus.ALU_In, 4'b1001);
      chk($sformatf("div_c%0d_busy", c), bus.Busy, 1);
    end
    chk("div_c7_dstart", bus.Div_Start, 0);
    drive(1'b0, 2'b00, 11'd0, 1'b1);
    step();
    drive(1'b0, 2'b00, 11'd0, 1'b0);
    chk("div_c8_busy", bus.Busy, 0);
    chk("div_c8_rdy", bus.In_Ready, 1);
    chk("div_c8_ov", bus.Out_Valid, 0);
    chk("div_c8_code", bus.ALU_In, 4'b1001);
    ov_seen = 0;
    for (int c = 9; c <= 20; c++) begin
      step();
      if (bus.Out_Valid !== 1'b0) ov_seen++;
    end
    chk("div_no_ov_to_c20", ov_seen, 0);

    // Flush together with In_Valid in IDLE: no accept
    drive(1'b1, 2'b10, 11'b11001011000, 1'b1);
    step();
    drive(1'b0, 2'b00, 11'd0, 1'b0);
    chk("fl_idle_ov", bus.Out_Valid, 0);
    chk("fl_idle_code", bus.ALU_In, 4'b1001);
    chk("fl_idle_busy", bus.Busy, 0);

    // Flush on the terminal-count cycle of a MUL (cycle 3)
    drive(1'b1, 2'b10, 11'b10011011000, 1'b0);
    step();
    drive(1'b0, 2'b00, 11'd0, 1'b0);
    step();
    step();
    drive(1'b0, 2'b00, 11'd0, 1'b1);
    step();
    drive(1'b0, 2'b00, 11'd0, 1'b0);
    chk("fl_tc_ov", bus.Out_Valid, 0);
    chk("fl_tc_busy", bus.Busy, 0);
    chk("fl_tc_code", bus.ALU_In, 4'b1000);
    step();
    chk("fl_tc_ov_late", bus.Out_Valid, 0);

    // asynchronous reset in cycle 2 of a MUL
    drive(1'b1, 2'b10, 11'b10011011000, 1'b0);
    step();
    drive(1'b0, 2'b00, 11'd0, 1'b0);
    step();
    chk("ar_pre_busy", bus.Busy, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("ar_busy", bus.Busy, 0);
    chk("ar_rdy", bus.In_Ready, 1);
    chk("ar_ov", bus.Out_Valid, 0);
    chk("ar_code", bus.ALU_In, 0);
    step();
    Reset_n = 1'b1;
    ov_seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.Out_Valid !== 1'b0) ov_seen++;
    end
    chk("ar_no_ov_after", ov_seen, 0);
    chk("ar_code_after", bus.ALU_In, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
